// File: rtl/cpu_pkg.sv
// Shared constants and types for the instruction fetch stage.
// The optional IFETCH_MISALIGN_CHECK_EN build uses the HALT state declared here.
package cpu_pkg;

    localparam int D_WIDTH = 32;
    localparam int A_WIDTH = 32;
    localparam logic [A_WIDTH-1:0] RESET_PC = 32'h0000_0000;
    localparam logic [D_WIDTH-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [D_WIDTH-1:0] instr;
        logic [A_WIDTH-1:0] pc;
    } buf_entry_t;

    function automatic logic [A_WIDTH-1:0] next_pc(input logic [A_WIDTH-1:0] pc);
        return pc + A_WIDTH'(4);
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction memory request/response channel between the fetch stage and memory.
// The fetch stage drives the request side as master; memory is the slave.
interface ifetch_unit_if #(
    parameter int A_WIDTH = cpu_pkg::A_WIDTH,
    parameter int D_WIDTH = cpu_pkg::D_WIDTH
) ();

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [A_WIDTH-1:0] imem_req_addr;
    logic               imem_rsp_valid;
    logic [D_WIDTH-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/ifetch_buf.sv
// Small synchronous FIFO holding fetched {instr, pc} entries ahead of the instruction register.
// Push and pop in the same cycle are accepted even when full; flush empties it in one cycle.
module ifetch_buf #(
    parameter type entry_t = cpu_pkg::buf_entry_t,
    parameter int  DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    input  logic                     flush,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               do_push;
    logic               do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns the PC, keeps one request outstanding and buffers responses for the IR.
// Define IFETCH_MISALIGN_CHECK_EN to trap misaligned redirects (fetch_misalign + HALT).
module ifetch_unit #(
    parameter int                 D_WIDTH   = cpu_pkg::D_WIDTH,
    parameter int                 A_WIDTH   = cpu_pkg::A_WIDTH,
    parameter logic [A_WIDTH-1:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter int                 BUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ifetch_unit_if.master        imem,
    input  logic                 redirect_valid,
    input  logic [A_WIDTH-1:0]   redirect_pc,
    input  logic                 stall,
    output logic [D_WIDTH-1:0]   isu,
    output logic                 ir_en,
    output logic [A_WIDTH-1:0]   pc_out
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    output logic                 fetch_misalign
`endif
);

    import cpu_pkg::*;

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    typedef struct packed {
        logic [D_WIDTH-1:0] instr;
        logic [A_WIDTH-1:0] pc;
    } entry_t;

    fetch_state_t       state_q;
    fetch_state_t       state_d;
    logic [A_WIDTH-1:0] pc_q;
    logic [A_WIDTH-1:0] pc_d;
    logic [A_WIDTH-1:0] req_pc_q;
    logic [A_WIDTH-1:0] req_pc_d;
    logic               drop_q;
    logic               drop_d;
    logic [A_WIDTH-1:0] target_pc;
    logic               misalign_hit;
    logic               req_valid;
    logic               accepted;
    logic               can_issue;
    logic [CNT_W-1:0]   free_slots;

    logic               buf_push;
    logic               buf_pop;
    logic               buf_flush;
    logic               buf_full;
    logic               buf_empty;
    logic [CNT_W-1:0]   buf_count;
    entry_t             buf_head;
    entry_t             buf_wdata;

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign target_pc    = redirect_pc;
    assign misalign_hit = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign target_pc    = redirect_pc & ~A_WIDTH'(3);
    assign misalign_hit = 1'b0;
`endif

    // The slot of an in-flight request is already spoken for.
    assign free_slots = CNT_W'(BUF_DEPTH) - buf_count - CNT_W'(state_q == WAIT);
    assign can_issue  = (free_slots != '0);
    assign accepted   = req_valid && imem.imem_req_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        drop_d    = drop_q;
        req_valid = 1'b0;
        buf_push  = 1'b0;
        buf_flush = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                req_valid = can_issue;
                if (req_valid && imem.imem_req_ready) begin
                    pc_d     = next_pc(pc_q);
                    req_pc_d = pc_q;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rsp_valid) begin
                    buf_push = !drop_q && (!buf_full || buf_pop);
                    drop_d   = 1'b0;
                    state_d  = REQ;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A redirect overrides everything above; a request already in memory is
        // marked so that its response is thrown away when it arrives.
        if (redirect_valid) begin
            buf_flush = 1'b1;
            buf_push  = 1'b0;
            pc_d      = target_pc;
            if (misalign_hit || state_q == HALT) begin
                state_d = HALT;
                drop_d  = 1'b0;
            end else begin
                case (state_q)
                    REQ: begin
                        if (accepted) begin
                            drop_d  = 1'b1;
                            state_d = WAIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    WAIT: begin
                        if (imem.imem_rsp_valid) begin
                            drop_d  = 1'b0;
                            state_d = REQ;
                        end else begin
                            drop_d  = 1'b1;
                            state_d = WAIT;
                        end
                    end
                    default: begin
                        state_d = REQ;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
        end
    end

`ifdef IFETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_misalign <= 1'b0;
        end else if (misalign_hit) begin
            fetch_misalign <= 1'b1;
        end
    end
`endif

    assign buf_wdata.instr = imem.imem_rsp_data;
    assign buf_wdata.pc    = req_pc_q;

    ifetch_buf #(
        .entry_t (entry_t),
        .DEPTH   (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (buf_push),
        .push_data (buf_wdata),
        .pop       (buf_pop),
        .flush     (buf_flush),
        .head      (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = pc_q;

    assign ir_en   = !buf_empty && !stall && !redirect_valid;
    assign buf_pop = ir_en;
    assign isu     = buf_empty ? '0 : buf_head.instr;
    assign pc_out  = buf_empty ? '0 : buf_head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: a latency-configurable memory model feeds an expected-entry queue.
// Build with IFETCH_MISALIGN_CHECK_EN to exercise the misaligned-redirect trap.
module tb_ifetch_unit;

    import cpu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic [31:0] isu;
    logic        ir_en;
    logic [31:0] pc_out;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic        fetch_misalign;
`endif

    ifetch_unit_if bus ();

    ifetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .isu            (isu),
        .ir_en          (ir_en),
        .pc_out         (pc_out)
`ifdef IFETCH_MISALIGN_CHECK_EN
        ,
        .fetch_misalign (fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    exp_t        expq[$];
    logic [31:0] acc_log[$];
    logic [31:0] ir_log[$];
    logic [31:0] exp_pc = RST_PC;
    logic        pend = 1'b0;
    logic        pend_kill = 1'b0;
    logic [31:0] pend_addr = '0;
    logic        halted = 1'b0;
    int          lat = 1;
    int          mem_cnt = 0;
    int          accepts = 0;
    int          ir_count = 0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5A00_0013;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Evaluated just before the rising edge, so it sees exactly what the edge will act on.
    task automatic monitorCycle();
        exp_t e;
        logic acc;
        acc = bus.imem_req_valid && bus.imem_req_ready;
        if (!rst_n) begin
            checkOutput("rst_ir_en", ir_en, 0);
            checkOutput("rst_req_valid", bus.imem_req_valid, 0);
            checkOutput("rst_req_addr", bus.imem_req_addr, RST_PC);
            checkOutput("rst_isu", isu, 0);
            checkOutput("rst_pc_out", pc_out, 0);
`ifdef IFETCH_MISALIGN_CHECK_EN
            checkOutput("rst_misalign", fetch_misalign, 0);
`endif
            expq.delete();
            exp_pc = RST_PC;
            pend_kill = 1'b1;
            halted = 1'b0;
            if (bus.imem_rsp_valid) pend = 1'b0;
            return;
        end
        if (stall || redirect_valid || halted) begin
            checkOutput("ir_en_blocked", ir_en, 0);
        end else if (expq.size() > 0) begin
            checkOutput("ir_en_ready", ir_en, 1);
        end else begin
            checkOutput("ir_en_idle", ir_en, 0);
        end
        if (ir_en) begin
            ir_count++;
            ir_log.push_back(pc_out);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checkOutput("pc_out", pc_out, e.pc);
                checkOutput("isu", isu, e.instr);
            end
        end
        if (halted) checkOutput("halt_req_valid", bus.imem_req_valid, 0);
        if (bus.imem_rsp_valid) begin
            if (pend && !pend_kill && !redirect_valid && !halted)
                expq.push_back('{pc: pend_addr, instr: memword(pend_addr)});
            pend = 1'b0;
        end
        if (acc) begin
            accepts++;
            acc_log.push_back(bus.imem_req_addr);
            checkOutput("one_outstanding", pend, 0);
            checkOutput("req_addr", bus.imem_req_addr, exp_pc);
            pend = 1'b1;
            pend_kill = redirect_valid;
            pend_addr = bus.imem_req_addr;
            mem_cnt = lat;
            exp_pc = exp_pc + 32'd4;
        end
        if (redirect_valid) begin
            expq.delete();
            if (pend) pend_kill = 1'b1;
`ifdef IFETCH_MISALIGN_CHECK_EN
            exp_pc = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) halted = 1'b1;
`else
            exp_pc = redirect_pc & ~32'd3;
`endif
        end
    endtask

    task automatic driveMemory();
        bus.imem_rsp_valid = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = memword(pend_addr);
            end
        end
    endtask

    // Redirect, when requested, is pulsed only in the first of the n cycles.
    task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rpc, input int n);
        for (int i = 0; i < n; i++) begin
            stall = st;
            redirect_valid = rv && (i == 0);
            redirect_pc = rpc;
            @(negedge clk);
            monitorCycle();
            @(posedge clk);
            #1;
            driveMemory();
        end
        redirect_valid = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 2);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int a0, c0, n;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        @(posedge clk);
        #1;

        // Test 1: streaming fetch, one instruction every two cycles
        lat = 1;
        doReset();
        for (n = 0; n < 20 && ir_count == 0; n++) applyStimulus(0, 0, 0, 1);
        checkOutput("t1_first_ir", ir_count > 0, 1);
        if (ir_log.size() > 0) checkOutput("t1_first_pc", ir_log[0], 32'h0);
        c0 = ir_count;
        applyStimulus(0, 0, 0, 20);
        checkOutput("t1_rate", ir_count - c0, 10);
        if (ir_log.size() > 2) checkOutput("t1_third_pc", ir_log[2], 32'h8);

        // Test 2: stall fills the buffer and blocks further requests
        doReset();
        a0 = accepts;
        applyStimulus(1, 0, 0, 10);
        checkOutput("t2_stall_accepts", accepts - a0, 2);
        c0 = ir_count;
        a0 = ir_log.size();
        applyStimulus(0, 0, 0, 2);
        checkOutput("t2_burst", ir_count - c0, 2);
        if (ir_log.size() >= a0 + 2) checkOutput("t2_burst_pc1", ir_log[a0 + 1], 32'h4);
        checkOutput("t2_resume_addr", acc_log[acc_log.size() - 1], 32'h8);
        applyStimulus(0, 0, 0, 6);

        // Test 3: redirect while a request is in flight
        doReset();
        lat = 3;
        for (n = 0; n < 20 && !pend; n++) applyStimulus(0, 0, 0, 1);
        checkOutput("t3_in_wait", pend, 1);
        a0 = acc_log.size();
        c0 = ir_log.size();
        applyStimulus(0, 1, 32'h100, 1);
        applyStimulus(0, 0, 0, 15);
        if (acc_log.size() > a0) checkOutput("t3_next_addr", acc_log[a0], 32'h100);
        else checkOutput("t3_no_accept", 0, 1);
        if (ir_log.size() > c0) checkOutput("t3_first_pc", ir_log[c0], 32'h100);
        else checkOutput("t3_no_delivery", 0, 1);

        // Test 4: request held while memory is not ready, then withdrawn by redirect
        lat = 1;
        bus.imem_req_ready = 1'b0;
        for (n = 0; n < 20 && !bus.imem_req_valid; n++) applyStimulus(0, 0, 0, 1);
        begin
            logic [31:0] hold_addr;
            hold_addr = bus.imem_req_addr;
            for (int i = 0; i < 5; i++) begin
                checkOutput("t4_valid_hold", bus.imem_req_valid, 1);
                checkOutput("t4_addr_hold", bus.imem_req_addr, hold_addr);
                applyStimulus(0, 0, 0, 1);
            end
        end
        applyStimulus(0, 1, 32'h40, 1);
        checkOutput("t4_withdraw", bus.imem_req_valid, 0);
        bus.imem_req_ready = 1'b1;
        a0 = acc_log.size();
        applyStimulus(0, 0, 0, 6);
        if (acc_log.size() > a0) checkOutput("t4_next_addr", acc_log[a0], 32'h40);
        else checkOutput("t4_no_accept", 0, 1);

        // Test 5: reset in the middle of a fetch with one entry buffered
        doReset();
        lat = 3;
        for (n = 0; n < 30 && !(expq.size() == 1 && pend); n++) applyStimulus(1, 0, 0, 1);
        checkOutput("t5_setup", expq.size() == 1 && pend, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_async_ir_en", ir_en, 0);
        checkOutput("t5_async_addr", bus.imem_req_addr, RST_PC);
        applyStimulus(1, 0, 0, 5);
        rst_n = 1'b1;
        a0 = acc_log.size();
        applyStimulus(0, 0, 0, 12);
        if (acc_log.size() > a0) checkOutput("t5_restart_addr", acc_log[a0], RST_PC);
        else checkOutput("t5_no_accept", 0, 1);

        // Test 6: misaligned redirect target
        lat = 1;
        doReset();
        applyStimulus(0, 0, 0, 4);
`ifdef IFETCH_MISALIGN_CHECK_EN
        applyStimulus(0, 1, 32'h102, 1);
        checkOutput("t6_misalign_set", fetch_misalign, 1);
        a0 = accepts;
        c0 = ir_count;
        applyStimulus(0, 0, 0, 10);
        checkOutput("t6_no_requests", accepts - a0, 0);
        checkOutput("t6_no_ir_en", ir_count - c0, 0);
        checkOutput("t6_misalign_sticky", fetch_misalign, 1);
        doReset();
        checkOutput("t6_misalign_cleared", fetch_misalign, 0);
`else
        applyStimulus(0, 1, 32'h102, 1);
        a0 = acc_log.size();
        applyStimulus(0, 0, 0, 8);
        if (acc_log.size() > a0) checkOutput("t6_aligned_addr", acc_log[a0], 32'h100);
        else checkOutput("t6_no_accept", 0, 1);
`endif
        applyStimulus(0, 0, 0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
